seg7_scan_display: RTL and testbench



---
 rtl/seg7_scan_display.sv | 261 ++++++++++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Display stage for the CPU result words. Two values are converted to BCD
//   in parallel by double-dabble lanes. Each finished conversion is latched
//   into an 8-digit shadow display with leading-zero blanking and overflow
//   ("EEEE") handling. A scan counter walks a single active-low digit enable
//   across the board.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   result1[31:0]  left value, shown on d7..d4 (low IN_W bits used)
//   result2[31:0]  right value, shown on d3..d0 (low IN_W bits used)
//   a..g           segment drives, active-high, registered
//   d0..d7         digit enables, active-low, registered
//
// Parameters
//   SCAN_DIV  cycles each digit stays enabled (>= 1)
//   IN_W      converted width of each result word (<= 16 so 5 BCD nibbles suffice)

// ---------------------------------------------------------------------------
// One double-dabble lane: load a binary value, then shift it into a 5-nibble
// BCD accumulator one bit per cycle.
// ---------------------------------------------------------------------------
module seg7_dd_lane #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [IN_W-1:0] bin_in,
  output logic [19:0]     bcd_out
);

  logic [IN_W-1:0] bin_q;
  logic [19:0]     bcd_q;
  logic [19:0]     bcd_adj;

  // Add 3 to any nibble >= 5 so the following shift carries correctly
  // into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 5; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5)
        bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load) begin
      bin_q <= bin_in;
      bcd_q <= '0;
    end else if (shift) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
    end
  end

  assign bcd_out = bcd_q;

endmodule

// ---------------------------------------------------------------------------
// Top level
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int SCAN_DIV = 50000,
  parameter int IN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result1,
  input  logic [31:0] result2,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        d0,
  output logic        d1,
  output logic        d2,
  output logic        d3,
  output logic        d4,
  output logic        d5,
  output logic        d6,
  output logic        d7
);

  localparam int NUM_GRP = 2;                 // group 0 = right, group 1 = left
  localparam int NUM_DIG = 8;
  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SC_W    = $clog2(IN_W + 1);

  // Display digit codes: 0..9 are decimal, plus two glyphs.
  localparam logic [3:0] DIG_E     = 4'hE;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_st_t;

  // -------------------------------------------------------------------------
  // Input selection; bits above IN_W are intentionally dropped.
  // -------------------------------------------------------------------------
  logic [NUM_GRP-1:0][IN_W-1:0] grp_bin;
  logic [NUM_GRP-1:0][19:0]     grp_bcd;

  assign grp_bin[0] = result2[IN_W-1:0];
  assign grp_bin[1] = result1[IN_W-1:0];

  generate
    if (IN_W < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{result1[31:IN_W], result2[31:IN_W]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Converter sequencing: IDLE -> LOAD -> SHIFT x IN_W -> COMMIT -> IDLE.
  // -------------------------------------------------------------------------
  conv_st_t        conv_st;
  logic [SC_W-1:0] shift_cnt;
  logic            conv_load;
  logic            conv_shift;
  logic            conv_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_st   <= ST_IDLE;
      shift_cnt <= '0;
    end else begin
      case (conv_st)
        ST_IDLE:   conv_st <= ST_LOAD;
        ST_LOAD: begin
          shift_cnt <= SC_W'(IN_W);
          conv_st   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_cnt <= shift_cnt - 1'b1;
          if (shift_cnt == SC_W'(1))
            conv_st <= ST_COMMIT;
        end
        ST_COMMIT: conv_st <= ST_IDLE;
        default:   conv_st <= ST_IDLE;
      endcase
    end
  end

  assign conv_load   = (conv_st == ST_LOAD);
  assign conv_shift  = (conv_st == ST_SHIFT);
  assign conv_commit = (conv_st == ST_COMMIT);

  generate
    for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_lane
      seg7_dd_lane #(.IN_W(IN_W)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .load    (conv_load),
        .shift   (conv_shift),
        .bin_in  (grp_bin[gi]),
        .bcd_out (grp_bcd[gi])
      );
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Formatting: overflow forces "EEEE"; otherwise leading zeros above the
  // units digit are blanked.
  // -------------------------------------------------------------------------
  function automatic logic [3:0][3:0] fmt_group(input logic [19:0] bcd);
    logic [3:0][3:0] r;
    if (bcd[19:16] != 4'd0) begin
      r = {4{DIG_E}};
    end else begin
      r[0] = bcd[3:0];
      r[1] = (bcd[15:4]  == 12'd0) ? DIG_BLANK : bcd[7:4];
      r[2] = (bcd[15:8]  == 8'd0)  ? DIG_BLANK : bcd[11:8];
      r[3] = (bcd[15:12] == 4'd0)  ? DIG_BLANK : bcd[15:12];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] dig);
    logic [6:0] s;
    case (dig)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      DIG_E:   s = 7'b1001111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Shadow display: both groups update together on COMMIT so a half-written
  // value is never scanned out. Reset value reads "   0" on each group.
  localparam logic [3:0][3:0] GRP_RST = {DIG_BLANK, DIG_BLANK, DIG_BLANK, 4'd0};

  logic [NUM_DIG-1:0][3:0] disp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= {GRP_RST, GRP_RST};
    end else if (conv_commit) begin
      disp_q <= {fmt_group(grp_bcd[1]), fmt_group(grp_bcd[0])};
    end
  end

  // -------------------------------------------------------------------------
  // Scan: each digit dwells SCAN_DIV cycles, index wraps 7 -> 0.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output register: one cycle behind scan_idx and disp_q, so a commit that
  // coincides with an index step shows the new value cleanly next cycle.
  // -------------------------------------------------------------------------
  logic [6:0]         seg_q;
  logic [NUM_DIG-1:0] dig_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      dig_n_q <= '1;
    end else begin
      seg_q   <= seg_code(disp_q[scan_idx]);
      dig_n_q <= ~(NUM_DIG'(1) << scan_idx);
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dig_n_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed and random result pairs, checked
// against a decimal-arithmetic model of what each digit position must show.
module tb_seg7_scan_display;

  localparam int SCAN_DIV = 4;
  localparam int IN_W     = 16;

  logic        clk;
  logic        rst;
  logic [31:0] result1;
  logic [31:0] result2;
  logic        a, b, c, d, e, f, g;
  logic        d0, d1, d2, d3, d4, d5, d6, d7;

  int total = 0;
  int bad   = 0;

  // scan tracking state
  bit track_ok;
  bit run_seen;
  int prev_pos;
  int run_len;

  seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .result1(result1), .result2(result2),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int dig);
    case (dig)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // What display position pos (0 = right units, 7 = left thousands) shows.
  function automatic logic [6:0] exp_seg(input int pos, input logic [31:0] vl,
                                         input logic [31:0] vr);
    int unsigned v;
    int unsigned pw;
    int p;
    v  = (pos >= 4) ? (vl & 32'h0000_FFFF) : (vr & 32'h0000_FFFF);
    p  = pos % 4;
    pw = 1;
    for (int k = 0; k < p; k++) pw = pw * 10;
    if (v > 9999) return 7'b1001111;
    if (p > 0 && v < pw) return 7'b0000000;
    return digit_seg(int'((v / pw) % 10));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    total++;
    assert ({a, b, c, d, e, f, g} === 7'b0000000) else begin
      bad++;
      $error("FAIL %s segs: got %b want 0000000", tag, {a, b, c, d, e, f, g});
    end
    total++;
    assert ({d7, d6, d5, d4, d3, d2, d1, d0} === 8'hFF) else begin
      bad++;
      $error("FAIL %s digits: got %b want 11111111", tag, {d7, d6, d5, d4, d3, d2, d1, d0});
    end
  endtask

  // Check the currently enabled digit against the model, plus scan order/dwell.
  task automatic chk_disp(input logic [31:0] vl, input logic [31:0] vr, input string tag);
    logic [7:0] dn;
    logic [6:0] segs;
    logic [6:0] want;
    int nlow;
    int pos;
    dn   = {d7, d6, d5, d4, d3, d2, d1, d0};
    segs = {a, b, c, d, e, f, g};
    nlow = 0;
    pos  = 0;
    for (int i = 0; i < 8; i++) if (!dn[i]) begin nlow++; pos = i; end
    total++;
    assert (nlow === 1) else begin
      bad++;
      $error("FAIL %s onehot: got digits %b want exactly one low", tag, dn);
    end
    if (nlow == 1) begin
      want = exp_seg(pos, vl, vr);
      total++;
      assert (segs === want) else begin
        bad++;
        $error("FAIL %s seg pos%0d: got %b want %b", tag, pos, segs, want);
      end
      if (!track_ok) begin
        track_ok = 1'b1;
        run_seen = 1'b0;
        prev_pos = pos;
        run_len  = 1;
      end else if (pos != prev_pos) begin
        total++;
        assert (pos === (prev_pos + 1) % 8) else begin
          bad++;
          $error("FAIL %s scan order: got pos%0d want pos%0d", tag, pos, (prev_pos + 1) % 8);
        end
        if (run_seen) begin
          total++;
          assert (run_len === SCAN_DIV) else begin
            bad++;
            $error("FAIL %s dwell pos%0d: got %0d want %0d", tag, prev_pos, run_len, SCAN_DIV);
          end
        end
        run_seen = 1'b1;
        prev_pos = pos;
        run_len  = 1;
      end else begin
        run_len++;
      end
    end
  endtask

  task automatic settle_and_observe(input logic [31:0] vl, input logic [31:0] vr,
                                    input string tag);
    result1 = vl;
    result2 = vr;
    repeat (2 * (IN_W + 3) + 2) tick();
    track_ok = 1'b0;
    for (int i = 0; i < 8 * SCAN_DIV; i++) begin
      tick();
      chk_disp(vl, vr, tag);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    repeat (n) tick();
    chk_dark(tag);
    rst      = 1'b0;
    track_ok = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 9999);
      2:       return ($urandom & 32'hFFFF_0000) | $urandom_range(0, 99);
      default: return $urandom_range(9995, 10005);
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    result1 = 32'd0;
    result2 = 32'd0;

    // reset state and first cycle after release
    do_reset(3, "reset");
    tick();
    total++;
    assert ({d7, d6, d5, d4, d3, d2, d1, d0} === 8'b1111_1110) else begin
      bad++;
      $error("FAIL first_digits: got %b want 11111110", {d7, d6, d5, d4, d3, d2, d1, d0});
    end
    total++;
    assert ({a, b, c, d, e, f, g} === 7'b1111110) else begin
      bad++;
      $error("FAIL first_segs: got %b want 1111110", {a, b, c, d, e, f, g});
    end

    // directed values
    settle_and_observe(32'd1234,  32'd56,         "v1234_56");
    settle_and_observe(32'd10000, 32'd9999,       "ovf_9999");
    settle_and_observe(32'd0,     32'hFFFF_0007,  "zero_hibits");
    settle_and_observe(32'd65535, 32'd10,         "max_10");

    // random pairs
    for (int n = 0; n < 16; n++) begin
      logic [31:0] r1;
      logic [31:0] r2;
      r1 = rand_val();
      r2 = rand_val();
      settle_and_observe(r1, r2, "random");
    end

    // input change during SHIFT: 12 committed first, 34 a refresh later
    result1 = 32'd0;
    result2 = 32'd12;
    do_reset(3, "reset2");
    for (int cyc = 1; cyc <= 70; cyc++) begin
      logic [31:0] wr;
      tick();
      wr = (cyc <= 19) ? 32'd0 : (cyc <= 38) ? 32'd12 : 32'd34;
      chk_disp(32'd0, wr, "shift_change");
      if (cyc == 7) result2 = 32'd34;
    end

    // reset during SHIFT aborts the 8888 conversion
    result1 = 32'd8888;
    result2 = 32'd5;
    do_reset(3, "reset3");
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      chk_disp(32'd0, 32'd0, "pre_abort");
    end
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk_dark("abort_rst");
    end
    rst      = 1'b0;
    track_ok = 1'b0;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      tick();
      if (cyc <= 19) chk_disp(32'd0, 32'd0, "post_abort");
      else           chk_disp(32'd8888, 32'd5, "after_abort");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
